// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory between CPU and EXT requesters.
// Latency MEM_LAT+1 cycles from grant to ack; optional locked EXT bursts via `MEM_ARB_LOCK_EN (adds ext_lock).
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int CW = 3;

  state_t        state;
  logic          owner;       // 0 = CPU, 1 = EXT
  logic          last_owner;
  logic          we_q;
  logic [CW-1:0] cnt;
`ifdef MEM_ARB_LOCK_EN
  logic          lock_q;
`endif

  logic grant_vld;
  logic grant_ext;

  always_comb begin
    grant_vld = cpu_req | ext_req;
    if (cpu_req && ext_req) grant_ext = ~last_owner;
    else                    grant_ext = ext_req;
`ifdef MEM_ARB_LOCK_EN
    if (lock_q && ext_req && ext_lock) grant_ext = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      ext_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MEM_ARB_LOCK_EN
          if (lock_q && !(ext_req && ext_lock)) lock_q <= 1'b0;
`endif
          if (grant_vld) begin
            owner     <= grant_ext;
            we_q      <= grant_ext ? ext_we : cpu_we;
            mem_addr  <= grant_ext ? ext_addr : cpu_addr;
            mem_wdata <= grant_ext ? ext_wdata : cpu_wdata;
            mem_we    <= grant_ext ? ext_we : cpu_we;
            mem_re    <= grant_ext ? ~ext_we : ~cpu_we;
            cnt       <= CW'(MEM_LAT - 1);
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_re <= 1'b0;
            if (!we_q) begin
              if (owner) ext_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            cpu_ack <= ~owner;
            ext_ack <= owner;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          last_owner <= owner;
          busy       <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
          lock_q     <= owner & ext_lock;
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and 3) against a transaction-schedule reference model.
module tb_mem_arbiter;
  localparam int NI  = 2;
  localparam int CPU = 0;
  localparam int EXT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req      [NI][2];
  logic        we       [NI][2];
  logic [15:0] addr     [NI][2];
  logic [15:0] wdata    [NI][2];
  logic        ack      [NI][2];
  logic [15:0] rdata    [NI][2];
  logic [15:0] mem_addr [NI];
  logic [15:0] mem_wdata[NI];
  logic [15:0] mem_rdata[NI];
  logic        mem_we   [NI];
  logic        mem_re   [NI];
  logic        busy     [NI];
  logic [15:0] mem_arr  [NI][256];
`ifdef MEM_ARB_LOCK_EN
  logic        ext_lock [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (req[g][0]),
      .cpu_we    (we[g][0]),
      .cpu_addr  (addr[g][0]),
      .cpu_wdata (wdata[g][0]),
      .cpu_ack   (ack[g][0]),
      .cpu_rdata (rdata[g][0]),
      .ext_req   (req[g][1]),
      .ext_we    (we[g][1]),
      .ext_addr  (addr[g][1]),
      .ext_wdata (wdata[g][1]),
      .ext_ack   (ack[g][1]),
      .ext_rdata (rdata[g][1]),
`ifdef MEM_ARB_LOCK_EN
      .ext_lock  (ext_lock[g]),
`endif
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_we    (mem_we[g]),
      .mem_re    (mem_re[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
    assign mem_rdata[g] = mem_arr[g][mem_addr[g][7:0]];
  end

  // Reference model: one transaction at a time, grant cycle g -> access g+1..g+L, ack at g+L+1.
  int          cyc;
  int          n_chk;
  int          n_fail;
  bit          rnd_en;
  bit          act     [NI];
  int          own     [NI];
  int          gcyc    [NI];
  logic        t_we    [NI];
  logic [15:0] t_addr  [NI];
  logic [15:0] t_wdata [NI];
  logic [15:0] t_rd    [NI];
  int          last    [NI];
  bit          lockm   [NI];
  logic [15:0] rexp    [NI][2];
  logic [15:0] shadow  [NI][256];
  bit          pend    [NI][2];
  int          rem     [NI][2];
  int          rsp_own [NI];
  int          lastack [NI][2];
  int          wecnt   [NI];
  int          acklog  [NI][16];
  int          nlog    [NI];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int i, input int o, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input int n);
    req[i][o]   = 1'b1;
    we[i][o]    = w;
    addr[i][o]  = a;
    wdata[i][o] = d;
    pend[i][o]  = 1'b1;
    rem[i][o]   = n;
  endtask

  task automatic model_reset(input int i);
    act[i]   = 1'b0;
    last[i]  = EXT;
    lockm[i] = 1'b0;
    for (int o = 0; o < 2; o++) begin
      rexp[i][o] = '0;
      pend[i][o] = 1'b0;
      rem[i][o]  = 0;
      req[i][o]  = 1'b0;
    end
  endtask

  task automatic arbitrate(input int i);
    int o;
    int L;
    L = lat(i);
    o = -1;
`ifdef MEM_ARB_LOCK_EN
    if (act[i] && cyc == gcyc[i] + L + 1) lockm[i] = (own[i] == EXT) && ext_lock[i];
`endif
    if (act[i] && cyc > gcyc[i] + L + 1) act[i] = 1'b0;
    if (act[i]) return;
`ifdef MEM_ARB_LOCK_EN
    if (lockm[i]) begin
      if (req[i][EXT] && ext_lock[i]) o = EXT;
      else lockm[i] = 1'b0;
    end
`endif
    if (o < 0) begin
      if (req[i][CPU] && req[i][EXT]) o = (last[i] == CPU) ? EXT : CPU;
      else if (req[i][CPU])           o = CPU;
      else if (req[i][EXT])           o = EXT;
    end
    if (o >= 0) begin
      act[i]     = 1'b1;
      own[i]     = o;
      last[i]    = o;
      gcyc[i]    = cyc;
      t_we[i]    = we[i][o];
      t_addr[i]  = addr[i][o];
      t_wdata[i] = wdata[i][o];
      t_rd[i]    = shadow[i][addr[i][o][7:0]];
      if (we[i][o]) shadow[i][addr[i][o][7:0]] = wdata[i][o];
    end
  endtask

  task automatic check_outs(input int i);
    int  L;
    bit  inb, acc, rsp;
    L   = lat(i);
    inb = act[i] && cyc >= gcyc[i] + 1 && cyc <= gcyc[i] + L + 1;
    acc = inb && cyc <= gcyc[i] + L;
    rsp = inb && cyc == gcyc[i] + L + 1;
    rsp_own[i] = rsp ? own[i] : -1;
    if (rsp && !t_we[i]) rexp[i][own[i]] = t_rd[i];
    chk($sformatf("u%0d.busy", i), busy[i], inb);
    chk($sformatf("u%0d.mem_we", i), mem_we[i], acc && t_we[i] && cyc == gcyc[i] + 1);
    chk($sformatf("u%0d.mem_re", i), mem_re[i], acc && !t_we[i]);
    chk($sformatf("u%0d.ack_excl", i), ack[i][0] & ack[i][1], 1'b0);
    if (acc) chk($sformatf("u%0d.mem_addr", i), mem_addr[i], t_addr[i]);
    if (acc && t_we[i]) chk($sformatf("u%0d.mem_wdata", i), mem_wdata[i], t_wdata[i]);
    for (int o = 0; o < 2; o++) begin
      chk($sformatf("u%0d.ack%0d", i, o), ack[i][o], rsp && own[i] == o);
      chk($sformatf("u%0d.rdata%0d", i, o), rdata[i][o], rexp[i][o]);
      if (ack[i][o]) lastack[i][o] = cyc;
    end
    if (rsp && nlog[i] < 16) begin
      acklog[i][nlog[i]] = own[i];
      nlog[i]++;
    end
    if (mem_we[i]) begin
      mem_arr[i][mem_addr[i][7:0]] = mem_wdata[i];
      wecnt[i]++;
    end
  endtask

  task automatic drive(input int i);
    for (int o = 0; o < 2; o++) begin
      if (pend[i][o] && rsp_own[i] == o) begin
        if (rem[i][o] > 0) begin
          rem[i][o]--;
          addr[i][o]  = 16'($urandom);
          wdata[i][o] = 16'($urandom);
        end else begin
          pend[i][o] = 1'b0;
          req[i][o]  = 1'b0;
        end
      end
      if (!pend[i][o] && rnd_en && $urandom_range(3) == 0)
        issue(i, o, 1'($urandom_range(1)), 16'($urandom), 16'($urandom), 0);
    end
`ifdef MEM_ARB_LOCK_EN
    if (rnd_en) ext_lock[i] = ($urandom_range(2) == 0);
`endif
  endtask

  task automatic step();
    for (int i = 0; i < NI; i++) arbitrate(i);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_outs(i);
      drive(i);
    end
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (pend[i][0] || pend[i][1]) b = 1'b1;
      if (act[i] && cyc <= gcyc[i] + lat(i) + 1) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run_idle(input int max_cyc);
    int n = 0;
    while (model_busy() && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", model_busy(), 1'b0);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      nlog[i]  = 0;
      wecnt[i] = 0;
    end
  endtask

  int c0;

  initial begin
    rst_n = 1'b0;
    cyc = 0; n_chk = 0; n_fail = 0; rnd_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int o = 0; o < 2; o++) begin
        we[i][o] = 1'b0; addr[i][o] = '0; wdata[i][o] = '0; lastack[i][o] = -1;
      end
      for (int a = 0; a < 256; a++) begin
        mem_arr[i][a] = 16'($urandom);
        shadow[i][a]  = mem_arr[i][a];
      end
      mem_arr[i][16] = 16'hA5A5;
      shadow[i][16]  = 16'hA5A5;
`ifdef MEM_ARB_LOCK_EN
      ext_lock[i] = 1'b0;
`endif
      model_reset(i);
    end
    clear_logs();
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.rst_mem_addr", i), mem_addr[i], 16'h0);
      chk($sformatf("u%0d.rst_mem_wdata", i), mem_wdata[i], 16'h0);
    end
    rst_n = 1'b1;
    step();

    // Single CPU read at 0x0010
    c0 = cyc;
    for (int i = 0; i < NI; i++) issue(i, CPU, 1'b0, 16'h0010, 16'h0, 0);
    run_idle(40);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.rd_lat", i), lastack[i][CPU] - c0, lat(i) + 1);
      chk($sformatf("u%0d.rd_data", i), rdata[i][CPU], 16'hA5A5);
      chk($sformatf("u%0d.rd_no_ext", i), lastack[i][EXT], 32'hFFFF_FFFF);
    end

    // EXT write 0x0003 <- 0x1234
    clear_logs();
    c0 = cyc;
    for (int i = 0; i < NI; i++) issue(i, EXT, 1'b1, 16'h0003, 16'h1234, 0);
    run_idle(40);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.wr_lat", i), lastack[i][EXT] - c0, lat(i) + 1);
      chk($sformatf("u%0d.wr_pulses", i), wecnt[i], 1);
      chk($sformatf("u%0d.wr_mem", i), mem_arr[i][3], 16'h1234);
    end

    // Requester address changes mid-transaction; latched address must be used
    for (int i = 0; i < NI; i++) issue(i, CPU, 1'b0, 16'h0010, 16'h0, 0);
    step();
    for (int i = 0; i < NI; i++) addr[i][CPU] = 16'h00FF;
    run_idle(40);
    for (int i = 0; i < NI; i++) chk($sformatf("u%0d.addr_chg_data", i), rdata[i][CPU], 16'hA5A5);

    // Reset during ACCESS of a CPU read
    for (int i = 0; i < NI; i++) issue(i, CPU, 1'b0, 16'h0010, 16'h0, 0);
    step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.rst_busy", i), busy[i], 1'b0);
      chk($sformatf("u%0d.rst_mem_re", i), mem_re[i], 1'b0);
      chk($sformatf("u%0d.rst_ack", i), ack[i][CPU], 1'b0);
      model_reset(i);
    end
    step();
    step();
    rst_n = 1'b1;

    // Tie after reset, then continuous contention: CPU, EXT, CPU, ...
    clear_logs();
    for (int i = 0; i < NI; i++) begin
      issue(i, CPU, 1'b0, 16'($urandom), 16'h0, 2);
      issue(i, EXT, 1'b1, 16'($urandom), 16'($urandom), 2);
    end
    run_idle(100);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.rr_count", i), nlog[i], 6);
      for (int k = 0; k < 6; k++) chk($sformatf("u%0d.rr_order%0d", i, k), acklog[i][k], k % 2);
    end

    // EXT alone right after an EXT transaction
    clear_logs();
    for (int i = 0; i < NI; i++) issue(i, EXT, 1'b0, 16'($urandom), 16'h0, 0);
    run_idle(40);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.ext_only_cnt", i), nlog[i], 1);
      chk($sformatf("u%0d.ext_only_own", i), acklog[i][0], EXT);
    end

`ifdef MEM_ARB_LOCK_EN
    // Locked EXT burst of three writes with CPU waiting
    clear_logs();
    for (int i = 0; i < NI; i++) begin
      ext_lock[i] = 1'b1;
      issue(i, EXT, 1'b1, 16'($urandom), 16'($urandom), 2);
    end
    step();
    for (int i = 0; i < NI; i++) issue(i, CPU, 1'b0, 16'($urandom), 16'h0, 0);
    run_idle(100);
    for (int i = 0; i < NI; i++) begin
      ext_lock[i] = 1'b0;
      chk($sformatf("u%0d.lock_cnt", i), nlog[i], 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("u%0d.lock_order%0d", i, k), acklog[i][k], (k < 3) ? EXT : CPU);
    end
`endif

    // Random traffic
    rnd_en = 1'b1;
    repeat (2000) step();
    rnd_en = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    for (int i = 0; i < NI; i++) ext_lock[i] = 1'b0;
`endif
    run_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
